wb_sprite_regs: RTL and testbench

Wishbone slave register bank holding position/enable state for `NUM_SPRITES` on-screen objects (player car plus opponent cars) in the racing display pipeline. Software writes pending coordinates at any time. The block commits them atomically to the pixel-side outputs on a frame-start pulse, so sprites never tear mid-frame. It raises a per-frame interrupt for game-loop pacing and generalises the single fixed player-car position register to N double-buffered, range-checked sprite slots.

---
 rtl/wb_sprite_regs.sv | 165 ++++++++++++++++
 tb/tb_wb_sprite_regs.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sprite_regs.sv
// rtl/wb_sprite_regs.sv - Wishbone sprite position register bank with frame-synchronous commit
// Defining WB_SPRITE_CLAMP_EN clamps stored coordinates to X_MAX/Y_MAX.
module wb_sprite_regs #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 10,
   parameter int X_MAX       = 639,
   parameter int Y_MAX       = 479
) (
   input  logic                                   wb_clk_i,
   input  logic                                   wb_rst_i,
   input  logic                                   wb_cyc_i,
   input  logic                                   wb_stb_i,
   input  logic                                   wb_we_i,
   input  logic [31:0]                            wb_adr_i,
   input  logic [3:0]                             wb_sel_i,
   input  logic [31:0]                            wb_dat_i,
   output logic [31:0]                            wb_dat_o,
   output logic                                   wb_ack_o,
   output logic                                   wb_err_o,
   output logic                                   wb_inta_o,
   input  logic                                   frame_start_i,
   output logic [NUM_SPRITES*(2*COORD_W+1)-1:0]   sprite_pos_o
);
   localparam int SW = 2*COORD_W + 1;
   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);
`ifdef WB_SPRITE_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   logic          irq_en;
   logic          immediate;
   logic          frame_pend;
   logic [7:0]    frame_cnt;
   logic [SW-1:0] pend [NUM_SPRITES];
   logic [SW-1:0] comm [NUM_SPRITES];

   logic [5:0]    rd_idx;
   logic          req;
   logic          rd_valid;
   logic [31:0]   rd_word;

   logic          wr_we;
   logic [5:0]    wr_idx;
   logic [3:0]    wr_sel;
   logic [31:0]   wr_dat;
   logic          wr_go;
   logic [31:0]   wr_mask;
   logic [31:0]   wr_old;
   logic [31:0]   wr_merged;
   logic [COORD_W-1:0] mx;
   logic [COORD_W-1:0] my;
   logic [SW-1:0] wr_slot_val;
   logic          unused_bits;

   function automatic logic [31:0] slot_word(input logic [SW-1:0] v);
      logic [31:0] w;
      w = '0;
      w[31]              = v[SW-1];
      w[10 +: COORD_W]   = v[COORD_W +: COORD_W];
      w[COORD_W-1:0]     = v[COORD_W-1:0];
      return w;
   endfunction

   assign rd_idx    = wb_adr_i[7:2];
   assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign rd_valid  = ({1'b0, rd_idx} < 7'(NUM_SPRITES + 2));
   assign wr_go     = wb_ack_o & wr_we;
   assign wb_inta_o = frame_pend & irq_en;

   always_comb begin
      rd_word = '0;
      case (rd_idx)
         6'd0:    rd_word = {30'd0, immediate, irq_en};
         6'd1:    rd_word = {16'd0, frame_cnt, 7'd0, frame_pend};
         default: begin
            for (int s = 0; s < NUM_SPRITES; s++)
               if (rd_idx == 6'(s + 2)) rd_word = slot_word(pend[s]);
         end
      endcase
   end

   // Byte-lane merge against the readback image, then optional clamp.
   always_comb begin
      wr_mask = {{8{wr_sel[3]}}, {8{wr_sel[2]}}, {8{wr_sel[1]}}, {8{wr_sel[0]}}};
      wr_old  = '0;
      case (wr_idx)
         6'd0:    wr_old = {30'd0, immediate, irq_en};
         6'd1:    wr_old = {16'd0, frame_cnt, 7'd0, frame_pend};
         default: begin
            for (int s = 0; s < NUM_SPRITES; s++)
               if (wr_idx == 6'(s + 2)) wr_old = slot_word(pend[s]);
         end
      endcase
      wr_merged = (wr_old & ~wr_mask) | (wr_dat & wr_mask);
      mx = wr_merged[COORD_W-1:0];
      my = wr_merged[10 +: COORD_W];
      if (CLAMP_EN && (mx > X_LIM)) mx = X_LIM;
      if (CLAMP_EN && (my > Y_LIM)) my = Y_LIM;
      wr_slot_val = {wr_merged[31], my, mx};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o   <= 1'b0;
         wb_err_o   <= 1'b0;
         wb_dat_o   <= '0;
         wr_we      <= 1'b0;
         wr_idx     <= '0;
         wr_sel     <= '0;
         wr_dat     <= '0;
         irq_en     <= 1'b0;
         immediate  <= 1'b0;
         frame_pend <= 1'b0;
         frame_cnt  <= '0;
         for (int s = 0; s < NUM_SPRITES; s++) begin
            pend[s] <= '0;
            comm[s] <= '0;
         end
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         if (req) begin
            wb_ack_o <= rd_valid;
            wb_err_o <= ~rd_valid;
            wr_we    <= wb_we_i;
            wr_idx   <= rd_idx;
            wr_sel   <= wb_sel_i;
            wr_dat   <= wb_dat_i;
            if (rd_valid && !wb_we_i) wb_dat_o <= rd_word;
         end

         // A frame start overrides a simultaneous W1C of frame_pend.
         if (frame_start_i) begin
            frame_cnt  <= frame_cnt + 8'd1;
            frame_pend <= 1'b1;
         end else if (wr_go && wr_idx == 6'd1 && wr_sel[0] && wr_dat[0]) begin
            frame_pend <= 1'b0;
         end

         if (wr_go && wr_idx == 6'd0) begin
            irq_en    <= wr_merged[0];
            immediate <= wr_merged[1];
         end

         // Commit samples the old pending value; an immediate write lands last and wins.
         for (int s = 0; s < NUM_SPRITES; s++) begin
            if (frame_start_i) comm[s] <= pend[s];
            if (wr_go && wr_idx == 6'(s + 2)) begin
               pend[s] <= wr_slot_val;
               if (immediate) comm[s] <= wr_slot_val;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
      assign sprite_pos_o[g*SW +: SW] = comm[g];
   end

   assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0], wr_merged};
endmodule

// File: tb/tb_wb_sprite_regs.sv
// tb/tb_wb_sprite_regs.sv - directed and randomized bench for wb_sprite_regs
// Expected values come from a behavioural model of the register map and frame commit.
module tb_wb_sprite_regs;
   localparam int N  = 4;
   localparam int CW = 10;
   localparam int SW = 2*CW + 1;
   localparam int XM = 639;
   localparam int YM = 479;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cyc = 1'b0;
   logic stb = 1'b0;
   logic we = 1'b0;
   logic [31:0] adr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat_w = '0;
   logic [31:0] dat_r;
   logic ack, err, inta;
   logic frame_start = 1'b0;
   logic [N*SW-1:0] pos;

   always #5 clk = ~clk;

   wb_sprite_regs #(.NUM_SPRITES(N), .COORD_W(CW), .X_MAX(XM), .Y_MAX(YM)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
      .wb_ack_o(ack), .wb_err_o(err), .wb_inta_o(inta),
      .frame_start_i(frame_start), .sprite_pos_o(pos)
   );

   int checks = 0;
   int errors = 0;

   int m_x[N], m_y[N], m_en[N];
   int c_x[N], c_y[N], c_en[N];
   int m_irq, m_imm, m_pend, m_cnt;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_x[k] = 0; m_y[k] = 0; m_en[k] = 0;
         c_x[k] = 0; c_y[k] = 0; c_en[k] = 0;
      end
      m_irq = 0; m_imm = 0; m_pend = 0; m_cnt = 0;
   endtask

   function automatic logic [31:0] model_word(input int idx);
      if (idx == 0) return 32'(m_imm * 2 + m_irq);
      if (idx == 1) return 32'(m_cnt * 256 + m_pend);
      if (idx >= 2 && idx < N + 2)
         return (32'(m_en[idx-2]) << 31) | (32'(m_y[idx-2]) << 10) | 32'(m_x[idx-2]);
      return 32'd0;
   endfunction

   function automatic logic [N*SW-1:0] model_pos();
      logic [N*SW-1:0] p;
      p = '0;
      for (int k = 0; k < N; k++)
         p[k*SW +: SW] = SW'(c_en[k] * (1 << (2*CW)) + c_y[k] * (1 << CW) + c_x[k]);
      return p;
   endfunction

   task automatic model_apply(input logic w, input int idx, input logic [3:0] s,
                              input logic [31:0] d, input logic fs);
      logic [31:0] word;
      int k;
      int imm_now;
      imm_now = m_imm;
      if (fs) begin
         for (int j = 0; j < N; j++) begin
            c_x[j] = m_x[j]; c_y[j] = m_y[j]; c_en[j] = m_en[j];
         end
         m_cnt = (m_cnt + 1) % 256;
      end
      if (w && idx < N + 2) begin
         word = model_word(idx);
         for (int b = 0; b < 4; b++)
            if (s[b]) word[b*8 +: 8] = d[b*8 +: 8];
         if (idx == 0) begin
            m_irq = int'(word[0]);
            m_imm = int'(word[1]);
         end else if (idx == 1) begin
            if (s[0] && d[0]) m_pend = 0;
         end else begin
            k = idx - 2;
            m_x[k]  = int'(word[CW-1:0]);
            m_y[k]  = int'(word[10 +: CW]);
            m_en[k] = int'(word[31]);
`ifdef WB_SPRITE_CLAMP_EN
            if (m_x[k] > XM) m_x[k] = XM;
            if (m_y[k] > YM) m_y[k] = YM;
`endif
            if (imm_now != 0) begin
               c_x[k] = m_x[k]; c_y[k] = m_y[k]; c_en[k] = m_en[k];
            end
         end
      end
      if (fs) m_pend = 1;
   endtask

   // One bus transaction; fs raises frame_start during the termination cycle.
   task automatic xfer(input logic w, input int idx, input logic [3:0] s,
                       input logic [31:0] d, input logic fs, output logic [31:0] rdata);
      logic valid;
      valid = (idx < N + 2);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(idx * 4); sel = s; dat_w = d;
      #1;
      check("ack_wait_state", {err, ack}, 2'b00);
      @(posedge clk); #1;
      check("ack", ack, valid);
      check("err", err, !valid);
      check("rdata", dat_r, (valid && !w) ? model_word(idx) : 32'd0);
      rdata = dat_r;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; frame_start = fs;
      @(posedge clk); #1;
      model_apply(w, idx, s, d, fs);
      check("term_one_cycle", {err, ack}, 2'b00);
      check("dat_idle", dat_r, 32'd0);
      check("sprite_pos", pos, model_pos());
      check("inta", inta, logic'(m_pend != 0 && m_irq != 0));
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic frame_pulse();
      @(negedge clk);
      frame_start = 1'b1;
      #1;
      check("pos_before_commit", pos, model_pos());
      @(posedge clk); #1;
      model_apply(1'b0, 0, 4'b0, 32'd0, 1'b1);
      check("pos_after_commit", pos, model_pos());
      check("inta_frame", inta, logic'(m_irq != 0));
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] wv;
      logic w;
      int idx;
      int nf;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {err, ack}, 2'b00);
      check("rst_pos", pos, '0);
      check("rst_inta", inta, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         xfer(1'b0, i, 4'hF, 32'd0, 1'b0, rd);
         check("rst_read_zero", rd, 32'd0);
      end

      xfer(1'b1, 2, 4'hF, 32'h8006_5131, 1'b0, rd);
      check("pos_before_frame", pos[0 +: SW], '0);
      frame_pulse();
      check("slot0_commit", pos[0 +: SW], {1'b1, 10'd404, 10'd305});
      xfer(1'b0, 1, 4'hF, 32'd0, 1'b0, rd);
      check("frame_cnt_1", rd[15:8], 8'd1);

      xfer(1'b1, 0, 4'hF, 32'd1, 1'b0, rd);
      frame_pulse();
      check("inta_high", inta, 1'b1);
      xfer(1'b1, 1, 4'hF, 32'd1, 1'b1, rd);
      xfer(1'b0, 1, 4'hF, 32'd0, 1'b0, rd);
      check("w1c_set_wins", rd[0], 1'b1);
      check("frame_cnt_3", rd[15:8], 8'd3);
      xfer(1'b1, 1, 4'h1, 32'd1, 1'b0, rd);
      check("inta_cleared", inta, 1'b0);

      xfer(1'b1, 3, 4'hF, 32'h8000_0000 | (32'd600 << 10) | 32'd1000, 1'b0, rd);
      xfer(1'b0, 3, 4'hF, 32'd0, 1'b0, rd);
`ifdef WB_SPRITE_CLAMP_EN
      check("clamp_readback", {rd[19:10], rd[9:0]}, {10'd479, 10'd639});
`else
      check("raw_readback", {rd[19:10], rd[9:0]}, {10'd600, 10'd1000});
`endif

      xfer(1'b0, 63, 4'hF, 32'd0, 1'b0, rd);
      xfer(1'b1, 4, 4'hF, 32'h8004_8123, 1'b0, rd);
      xfer(1'b1, 4, 4'h1, 32'hFFFF_FFAB, 1'b0, rd);
      xfer(1'b0, 4, 4'hF, 32'd0, 1'b0, rd);
      check("byte_lane0", rd, 32'h8004_81AB);
      xfer(1'b1, 4, 4'h0, 32'h0000_0000, 1'b0, rd);
      xfer(1'b0, 4, 4'hF, 32'd0, 1'b0, rd);
      check("sel_zero", rd, 32'h8004_81AB);

      xfer(1'b1, 0, 4'hF, 32'd2, 1'b0, rd);
      xfer(1'b1, 5, 4'hF, 32'h8001_9064, 1'b0, rd);
      check("immediate_commit", pos[3*SW +: SW], {1'b1, 10'd100, 10'd100});
      xfer(1'b1, 5, 4'hF, 32'h0000_2C05, 1'b1, rd);
      check("immediate_wins", pos[3*SW +: SW], {1'b0, 10'd11, 10'd5});
      xfer(1'b1, 0, 4'hF, 32'd0, 1'b0, rd);
      xfer(1'b1, 2, 4'hF, 32'h8000_0401, 1'b1, rd);
      check("commit_pre_write", pos[0 +: SW], {1'b1, 10'd404, 10'd305});
      frame_pulse();
      check("commit_next_frame", pos[0 +: SW], {1'b1, 10'd1, 10'd1});

      for (int i = 0; i < 60; i++) begin
         idx = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 7));
         w   = logic'($urandom_range(0, 1));
         wv  = $urandom;
         xfer(w, idx, 4'($urandom), wv, logic'($urandom_range(0, 3) == 0), rd);
      end
      for (int i = 0; i < N + 2; i++) xfer(1'b0, i, 4'hF, 32'd0, 1'b0, rd);

      nf = (256 - m_cnt) % 256;
      for (int i = 0; i < nf; i++) frame_pulse();
      xfer(1'b0, 1, 4'hF, 32'd0, 1'b0, rd);
      check("frame_cnt_zero", rd[15:8], 8'd0);
      for (int i = 0; i < 256; i++) frame_pulse();
      xfer(1'b0, 1, 4'hF, 32'd0, 1'b0, rd);
      check("frame_cnt_wrap", rd[15:8], 8'd0);

      xfer(1'b1, 0, 4'hF, 32'd1, 1'b0, rd);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd8; sel = 4'hF; dat_w = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("mid_ack", ack, 1'b1);
      @(negedge clk);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check("mid_rst_ack", {err, ack}, 2'b00);
      check("mid_rst_pos", pos, '0);
      check("mid_rst_inta", inta, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N + 2; i++) xfer(1'b0, i, 4'hF, 32'd0, 1'b0, rd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
